// File: rtl/pll_reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reset_sequencer_pkg
//  Description : Shared types and sizing helpers for the PLL reset sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_reset_sequencer_pkg;

  // Sequencer phases, in the order a healthy bring-up walks through them.
  typedef enum logic [1:0] {
    ST_PLL_RESET = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  // A cycle-count parameter of 0 or 1 both mean "one cycle".
  function automatic int unsigned eff_cycles(input int unsigned p);
    return (p < 1) ? 1 : p;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : 1-bit two-flop synchronizer, both stages reset to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: shift the async input through the two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer stages with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reset_sequencer
//  Description : Pulses the PLL reset, waits for a stable lock and releases
//                the downstream reset; re-arms on timeout or lock loss.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [7:0] timeout_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned c_rst_cyc    = eff_cycles(RST_CYCLES);
  localparam int unsigned c_lock_cyc   = eff_cycles(LOCK_TIMEOUT);
  localparam int unsigned c_stable_cyc = eff_cycles(STABLE_CYCLES);
  localparam int unsigned c_cnt_w      = cnt_width(max3(c_rst_cyc, c_lock_cyc, c_stable_cyc));

  // PLL_RESET and WAIT_LOCK leave on the edge that closes their N-th cycle.
  // STABLE leaves one edge later, so lock has been seen on STABLE_CYCLES
  // full cycles after the entry edge before downstream reset is released.
  localparam logic [c_cnt_w-1:0] c_rst_last   = c_cnt_w'(c_rst_cyc - 1);
  localparam logic [c_cnt_w-1:0] c_lock_last  = c_cnt_w'(c_lock_cyc - 1);
  localparam logic [c_cnt_w-1:0] c_stable_end = c_cnt_w'(c_stable_cyc);
  localparam logic [c_cnt_w-1:0] c_cnt_max    = {c_cnt_w{1'b1}};

  state_e               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic                 started_q, started_d;
  logic                 pll_rst_q, pll_rst_d;
  logic                 sys_rst_n_q, sys_rst_n_d;
  logic                 ready_q, ready_d;
  logic [7:0]           timeout_cnt_q, timeout_cnt_d;
  logic [7:0]           lock_loss_cnt_q, lock_loss_cnt_d;
  logic                 locked_s;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // Next-state, event counters and phase counter.
  always_comb begin
    state_d         = state_q;
    timeout_cnt_d   = timeout_cnt_q;
    lock_loss_cnt_d = lock_loss_cnt_q;
    started_d       = 1'b1;

    case (state_q)
      ST_PLL_RESET: begin
        // The first edge out of reset restarts the pulse from zero.
        if (started_q && (cnt_q == c_rst_last)) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a timeout expiring on the same edge.
        if (locked_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == c_lock_last) begin
          state_d = ST_PLL_RESET;
          if (timeout_cnt_q != 8'hFF) timeout_cnt_d = timeout_cnt_q + 8'd1;
        end
      end
      ST_STABLE: begin
        if (!locked_s)                    state_d = ST_WAIT_LOCK;
        else if (cnt_q == c_stable_end)   state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_PLL_RESET;
          if (lock_loss_cnt_q != 8'hFF) lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_PLL_RESET;
    endcase

    if ((state_d != state_q) || !started_q) cnt_d = '0;
    else if (cnt_q != c_cnt_max)            cnt_d = cnt_q + c_cnt_w'(1);
    else                                    cnt_d = cnt_q;

    pll_rst_d   = (state_d == ST_PLL_RESET);
    sys_rst_n_d = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
  end

  // State, counters and registered outputs.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q         <= ST_PLL_RESET;
      cnt_q           <= '0;
      started_q       <= 1'b0;
      pll_rst_q       <= 1'b1;
      sys_rst_n_q     <= 1'b0;
      ready_q         <= 1'b0;
      timeout_cnt_q   <= 8'd0;
      lock_loss_cnt_q <= 8'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      started_q       <= started_d;
      pll_rst_q       <= pll_rst_d;
      sys_rst_n_q     <= sys_rst_n_d;
      ready_q         <= ready_d;
      timeout_cnt_q   <= timeout_cnt_d;
      lock_loss_cnt_q <= lock_loss_cnt_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign ready         = ready_q;
  assign timeout_cnt   = timeout_cnt_q;
  assign lock_loss_cnt = lock_loss_cnt_q;

endmodule
`default_nettype wire
